// File: rtl/multicycle_controller.sv
// Control FSM for the shared-ALU multicycle RV32I datapath: per-state mux selects,
// write enables, ALU function and immediate format, plus a retired-instruction counter.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             neg,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       alu_ctrl,
  output logic [2:0]       imm_src,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             taken;

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_fn = sub ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = 3'b101;
      3'b100:  alu_fn = 3'b100;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_fn = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target OldPC+imm lands in ALUOut for BRANCH to use.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_fn(funct3, funct7b5);
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        // funct7b5 is part of the immediate here, so it never selects sub.
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_fn(funct3, 1'b0);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = ALU_SUB;
        pc_write   = taken;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes hand-computed per-instruction signatures, a negedge
// monitor accumulates the DUT's per-cycle outputs and compares at each instr_done.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic [31:0] retired;

  logic        pc_write4, adr_src4, mem_write4, ir_write4, reg_write4, instr_done4;
  logic [1:0]  alu_src_a4, alu_src_b4, result_src4;
  logic [2:0]  alu_ctrl4, imm_src4;
  logic [3:0]  retired4;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .instr_done(instr_done), .retired(retired)
  );

  multicycle_controller #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .pc_write(pc_write4), .adr_src(adr_src4),
    .mem_write(mem_write4), .ir_write(ir_write4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .result_src(result_src4),
    .alu_ctrl(alu_ctrl4), .imm_src(imm_src4), .instr_done(instr_done4), .retired(retired4)
  );

  typedef struct {
    int          cyc, npc, nreg, nmem, nadr;
    logic [2:0]  alu;
    logic [1:0]  wb;
    logic [11:0] atr, btr;
    logic [2:0]  imm;
    logic [31:0] ret;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_ret = 0;
  logic rst_seen = 1'b0;

  int          m_cyc = 0, m_npc = 0, m_nreg = 0, m_nmem = 0, m_nadr = 0;
  logic [2:0]  m_alu = '0;
  logic [1:0]  m_wb = '0;
  logic [11:0] m_atr = '0, m_btr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) rst_seen <= rst;

  // Monitor: reset behaviour every cycle, instruction signature at each instr_done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_enables", 32'({pc_write, ir_write, mem_write, reg_write, instr_done}), 32'd0);
      if (rst_seen) chk("rst_retired", retired, 32'd0);
    end else begin
      if (rst_seen) begin
        chk("post_rst_fetch", 32'({ir_write, pc_write, alu_src_b}), 32'b1110);
        chk("post_rst_retired", retired, 32'd0);
      end
      if (ir_write) begin
        m_cyc = 0; m_npc = 0; m_nreg = 0; m_nmem = 0; m_nadr = 0;
        m_alu = '0; m_wb = '0; m_atr = '0; m_btr = '0;
      end
      m_cyc++;
      m_npc  += int'(pc_write);
      m_nreg += int'(reg_write);
      m_nmem += int'(mem_write);
      m_nadr += int'(adr_src);
      m_alu  |= alu_ctrl;
      if (reg_write) m_wb = result_src;
      m_atr = {m_atr[9:0], alu_src_a};
      m_btr = {m_btr[9:0], alu_src_b};
      if (instr_done) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk({e.name, ".cycles"}, 32'(m_cyc), 32'(e.cyc));
          chk({e.name, ".pc_write"}, 32'(m_npc), 32'(e.npc));
          chk({e.name, ".reg_write"}, 32'(m_nreg), 32'(e.nreg));
          chk({e.name, ".mem_write"}, 32'(m_nmem), 32'(e.nmem));
          chk({e.name, ".adr_src"}, 32'(m_nadr), 32'(e.nadr));
          chk({e.name, ".alu_ctrl"}, 32'(m_alu), 32'(e.alu));
          chk({e.name, ".wb_src"}, 32'(m_wb), 32'(e.wb));
          chk({e.name, ".a_trace"}, 32'(m_atr), 32'(e.atr));
          chk({e.name, ".b_trace"}, 32'(m_btr), 32'(e.btr));
          chk({e.name, ".imm_src"}, 32'(imm_src), 32'(e.imm));
          chk({e.name, ".retired"}, retired, e.ret);
          chk({e.name, ".retired4"}, 32'(retired4), {28'd0, e.ret[3:0]});
        end
      end
    end
  end

  // Called during a FETCH cycle; returns #1 after the edge into the next FETCH.
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic n,
                     input int cyc, input int npc, input int nreg, input int nmem,
                     input int nadr, input logic [2:0] alu, input logic [1:0] wb,
                     input logic [11:0] atr, input logic [11:0] btr, input logic [2:0] imm);
    exp_t e;
    int   k;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    e.name = nm; e.cyc = cyc; e.npc = npc; e.nreg = nreg; e.nmem = nmem; e.nadr = nadr;
    e.alu = alu; e.wb = wb; e.atr = atr; e.btr = btr; e.imm = imm; e.ret = 32'(n_ret);
    n_ret++;
    sb_q.push_back(e);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_done) break;
    end
    if (k == 20) begin
      $display("FAIL %s timeout actual=no_instr_done required=instr_done", nm);
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011, S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011, J = 7'b1101111, JR = 7'b1100111, U = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_ret = 0;
    //  name    op  f3      f7 z  n  cyc pc rg mw ad alu     wb     a_trace  b_trace  imm
    run("add",  R,  3'b000, 0, 1, 1, 4,  1, 1, 0, 0, 3'b000, 2'b00, 12'h018, 12'h090, 3'b000);
    run("sub",  R,  3'b000, 1, 0, 0, 4,  1, 1, 0, 0, 3'b001, 2'b00, 12'h018, 12'h090, 3'b000);
    run("and",  R,  3'b111, 0, 0, 0, 4,  1, 1, 0, 0, 3'b010, 2'b00, 12'h018, 12'h090, 3'b000);
    run("or",   R,  3'b110, 1, 0, 0, 4,  1, 1, 0, 0, 3'b011, 2'b00, 12'h018, 12'h090, 3'b000);
    run("slt",  R,  3'b010, 0, 0, 0, 4,  1, 1, 0, 0, 3'b101, 2'b00, 12'h018, 12'h090, 3'b000);
    run("xor",  R,  3'b100, 0, 0, 0, 4,  1, 1, 0, 0, 3'b100, 2'b00, 12'h018, 12'h090, 3'b000);
    run("sll",  R,  3'b001, 1, 0, 0, 4,  1, 1, 0, 0, 3'b000, 2'b00, 12'h018, 12'h090, 3'b000);
    run("lw",   L,  3'b010, 0, 0, 0, 5,  1, 1, 0, 1, 3'b000, 2'b01, 12'h060, 12'h250, 3'b000);
    run("sw",   S,  3'b010, 0, 0, 0, 4,  1, 0, 1, 1, 3'b000, 2'b00, 12'h018, 12'h094, 3'b001);
    run("beq1", B,  3'b000, 0, 1, 0, 3,  2, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("beq0", B,  3'b000, 0, 0, 0, 3,  1, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("blt1", B,  3'b100, 0, 0, 1, 3,  2, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("bge1", B,  3'b101, 0, 0, 1, 3,  1, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("bge0", B,  3'b101, 0, 0, 0, 3,  2, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("bne0", B,  3'b001, 0, 0, 0, 3,  2, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("bne1", B,  3'b001, 0, 1, 0, 3,  1, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("b010", B,  3'b010, 0, 1, 1, 3,  1, 0, 0, 0, 3'b001, 2'b00, 12'h006, 12'h024, 3'b010);
    run("jal",  J,  3'b000, 0, 1, 1, 4,  2, 1, 0, 0, 3'b000, 2'b00, 12'h014, 12'h098, 3'b011);
    run("jalr", JR, 3'b000, 0, 0, 0, 5,  2, 1, 0, 0, 3'b000, 2'b00, 12'h064, 12'h258, 3'b000);
    run("lui",  U,  3'b000, 0, 0, 0, 3,  1, 1, 0, 0, 3'b000, 2'b11, 12'h004, 12'h024, 3'b100);
    run("ill",  BAD,3'b000, 0, 0, 0, 2,  1, 0, 0, 0, 3'b000, 2'b00, 12'h001, 12'h009, 3'b000);
    run("addi", I,  3'b000, 1, 0, 0, 4,  1, 1, 0, 0, 3'b000, 2'b00, 12'h018, 12'h094, 3'b000);
    run("slti", I,  3'b010, 0, 0, 0, 4,  1, 1, 0, 0, 3'b101, 2'b00, 12'h018, 12'h094, 3'b000);
    run("xori", I,  3'b100, 0, 0, 0, 4,  1, 1, 0, 0, 3'b100, 2'b00, 12'h018, 12'h094, 3'b000);
    run("ori",  I,  3'b110, 0, 0, 0, 4,  1, 1, 0, 0, 3'b011, 2'b00, 12'h018, 12'h094, 3'b000);
    run("andi", I,  3'b111, 0, 0, 0, 4,  1, 1, 0, 0, 3'b010, 2'b00, 12'h018, 12'h094, 3'b000);

    // Abandon a load in MEMREAD; the monitor checks the forced-off enables and restart.
    op = L; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_ret = 0;

    for (int i = 0; i < 17; i++)
      run("wrap", BAD, 3'b000, 0, 0, 0, 2, 1, 0, 0, 0, 3'b000, 2'b00, 12'h001, 12'h009, 3'b000);
    run("add2", R,  3'b000, 0, 0, 0, 4,  1, 1, 0, 0, 3'b000, 2'b00, 12'h018, 12'h090, 3'b000);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
